gpi_debounce: RTL and testbench
===============================

// Module: gpi_debounce
// PURPOSE
//  Input conditioner directly upstream of the GPI slot: synchronizes W raw external inputs
//  (switches, buttons), debounces each bit independently, emits per-bit edge pulses.
//  db_level drives the GPI slot's din port; rise/fall pulses feed the interrupt/event logic.
// PARAMETERS
//  W           8   number of input bits
//  SYNC_STAGES 2   synchronizer flop depth (>=2)
//  TICK_W      16  prescaler width; sample tick every 2**TICK_W clk cycles
//  N_STABLE    4   consecutive ticks an input must hold a new value before acceptance (>=1)
// PORTS
//  clk        in   1  system clock
//  reset      in   1  asynchronous, active-low reset
//  raw_in     in   W  asynchronous external inputs
//  db_level   out  W  debounced stable level (to GPI slot din)
//  rise_tick  out  W  1-cycle pulse per bit on accepted 0->1
//  fall_tick  out  W  1-cycle pulse per bit on accepted 1->0
//  clr_flag   in   W  per-bit clear for edge_flag (ignored without GPI_EDGE_LATCH_EN)
//  edge_flag  out  W  sticky edge-seen flags (0 without GPI_EDGE_LATCH_EN)
// BEHAVIOUR
//  - Reset (reset=0): all flops cleared immediately; every output 0; all cells in ZERO.
//  - Sync: raw_in passes SYNC_STAGES flops -> s[W-1:0]; no other logic samples raw_in.
//  - Prescaler: free-running TICK_W counter, wraps all-ones -> 0; tick=1 for exactly the
//    cycle the counter is all-ones; shared by all bits.
//  - Per-bit FSM, states ZERO, WAIT1, ONE, WAIT0; counter cnt, width $clog2(N_STABLE+1):
//    ZERO : db=0; s=1 -> WAIT1, cnt<=0.
//    WAIT1: db=0; s=0 -> ZERO (revert wins over tick); s=1&tick -> cnt++;
//           s=1 & tick & cnt==N_STABLE-1 -> ONE.
//    ONE  : db=1; s=0 -> WAIT0, cnt<=0.
//    WAIT0: mirror of WAIT1 (db=1, s=1 reverts to ONE, N_STABLE ticks at 0 -> ZERO).
//  - db_level, rise_tick, fall_tick are registered: they change on the same edge the FSM
//    enters ONE/ZERO from WAIT1/WAIT0; each pulse is exactly 1 cycle.
//  - Tick in the cycle of entry into WAITx is not counted (state not yet WAITx).
//  - Latency, clean step on raw_in: SYNC_STAGES + 1 cycles to WAITx, then acceptance on the
//    N_STABLE-th tick: total in [SYNC_STAGES+1+(N_STABLE-1)*2**TICK_W+1,
//    SYNC_STAGES+1+N_STABLE*2**TICK_W].
//  - Any glitch shorter than one tick period never changes db_level nor pulses.
//  - Bits are fully independent; simultaneous edges on several bits each pulse.
// CONFIGURATION
//  GPI_EDGE_LATCH_EN defined: edge_flag[i] set by rise_tick[i]|fall_tick[i], cleared by
//    clr_flag[i]; set and clear in same cycle -> flag stays 1 (set wins); reset -> 0.
//  Not defined: edge_flag tied to 0, clr_flag unused, no flag flops synthesized.
// STRUCTURE
//  - gpi_pkg: typedef enum logic [1:0] db_state_t {ZERO, WAIT1, ONE, WAIT0}.
//  - Sub-module gpi_db_cell: one-bit FSM + cnt + registered db/rise/fall; instantiated W times
//    in a generate loop; synchronizer, prescaler and edge-flag logic stay in gpi_debounce.
// TESTING  (bench uses W=4, SYNC_STAGES=2, TICK_W=2 (tick every 4 cycles), N_STABLE=3)
//  1. Assert reset with raw_in=4'hF, release -> all outputs 0 during reset; db_level=4'hF
//     after acceptance, rise_tick=4'hF for exactly 1 cycle.
//  2. raw_in[0] 0->1 held -> db_level[0]=1 within 12..15 cycles of the change;
//     rise_tick[0] one cycle, coincident with db_level[0] rise; other bits unchanged.
//  3. raw_in[1] toggling every 3 cycles for 40 cycles then held 0 -> db_level[1] stays 0;
//     no rise/fall pulses on bit 1.
//  4. raw_in[2] high for exactly 1 cycle aligned so s[2] returns to 0 on a tick cycle ->
//     revert wins; no transition, no pulse.
//  5. reset asserted while bit 0 in WAIT1 -> outputs 0 asynchronously; after release with
//     raw_in=0 no rise_tick ever occurs.
//  6. GPI_EDGE_LATCH_EN: fall on bit 3 -> edge_flag[3]=1; clr_flag[3] alone -> 0;
//     clr_flag[3] pulsed in same cycle as new rise_tick[3] -> edge_flag[3]=1.
//     Without macro: edge_flag==0 throughout all scenarios.

Source files
------------

// File: rtl/gpi_pkg.sv
// ============================================================================
//  gpi_pkg : shared types for the GPI input debouncer
//  Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package gpi_pkg;

    typedef enum logic [1:0] {
        ZERO  = 2'd0,
        WAIT1 = 2'd1,
        ONE   = 2'd2,
        WAIT0 = 2'd3
    } db_state_t;

endpackage

`default_nettype wire

// File: rtl/gpi_db_cell.sv
// ============================================================================
//  gpi_db_cell : one-bit debounce FSM with tick counter and registered
//                level / rise / fall outputs
//  Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module gpi_db_cell
    import gpi_pkg::*;
#(
    parameter int N_STABLE = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic s,
    input  logic tick,
    output logic db,
    output logic rise,
    output logic fall
);

    localparam int C_CNT_W = $clog2(N_STABLE + 1);

    db_state_t            r_state;
    db_state_t            w_state_nxt;
    logic [C_CNT_W-1:0]   r_cnt;
    logic [C_CNT_W-1:0]   w_cnt_nxt;
    logic                 w_last;
    logic                 w_db_nxt;
    logic                 w_rise_nxt;
    logic                 w_fall_nxt;

    assign w_last = (r_cnt == C_CNT_W'(N_STABLE - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ZERO;
            r_cnt   <= '0;
            db      <= 1'b0;
            rise    <= 1'b0;
            fall    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            db      <= w_db_nxt;
            rise    <= w_rise_nxt;
            fall    <= w_fall_nxt;
        end
    end

    // A revert to the old level takes priority over a tick in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ZERO: begin
                if (s) begin
                    w_state_nxt = WAIT1;
                    w_cnt_nxt   = '0;
                end
            end
            WAIT1: begin
                if (!s) begin
                    w_state_nxt = ZERO;
                end else if (tick) begin
                    if (w_last) w_state_nxt = ONE;
                    else        w_cnt_nxt   = r_cnt + C_CNT_W'(1);
                end
            end
            ONE: begin
                if (!s) begin
                    w_state_nxt = WAIT0;
                    w_cnt_nxt   = '0;
                end
            end
            WAIT0: begin
                if (s) begin
                    w_state_nxt = ONE;
                end else if (tick) begin
                    if (w_last) w_state_nxt = ZERO;
                    else        w_cnt_nxt   = r_cnt + C_CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ZERO;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        w_db_nxt   = (w_state_nxt == ONE) || (w_state_nxt == WAIT0);
        w_rise_nxt = (r_state == WAIT1) && (w_state_nxt == ONE);
        w_fall_nxt = (r_state == WAIT0) && (w_state_nxt == ZERO);
    end

endmodule

`default_nettype wire

// File: rtl/gpi_debounce.sv
// ============================================================================
//  gpi_debounce : W-bit synchronizer + per-bit debouncer + edge pulses.
//                 Optional sticky edge flags under GPI_EDGE_LATCH_EN.
//  Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module gpi_debounce
    import gpi_pkg::*;
#(
    parameter int W           = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TICK_W      = 16,
    parameter int N_STABLE    = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] raw_in,
    output logic [W-1:0] db_level,
    output logic [W-1:0] rise_tick,
    output logic [W-1:0] fall_tick,
    input  logic [W-1:0] clr_flag,
    output logic [W-1:0] edge_flag
);

    logic [W-1:0]      r_sync [SYNC_STAGES];
    logic [W-1:0]      w_s;
    logic [TICK_W-1:0] r_presc;
    logic              w_tick;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
        end else begin
            r_sync[0] <= raw_in;
            for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
        end
    end

    assign w_s = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_presc <= '0;
        else        r_presc <= r_presc + TICK_W'(1);
    end

    assign w_tick = &r_presc;

    for (genvar gi = 0; gi < W; gi++) begin : g_cell
        gpi_db_cell #(
            .N_STABLE (N_STABLE)
        ) u_cell (
            .clk   (clk),
            .reset (reset),
            .s     (w_s[gi]),
            .tick  (w_tick),
            .db    (db_level[gi]),
            .rise  (rise_tick[gi]),
            .fall  (fall_tick[gi])
        );
    end

`ifdef GPI_EDGE_LATCH_EN
    logic [W-1:0] r_edge_flag;

    // New edges win over a simultaneous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_edge_flag <= '0;
        else        r_edge_flag <= (r_edge_flag & ~clr_flag) | rise_tick | fall_tick;
    end

    assign edge_flag = r_edge_flag;
`else
    logic w_unused_clr;
    assign w_unused_clr = ^clr_flag;
    assign edge_flag    = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_gpi_debounce.sv
// ============================================================================
//  tb_gpi_debounce : randomized + directed bench for gpi_debounce against
//                    a behavioural acceptance model
//  Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_gpi_debounce;

    localparam int W  = 4;
    localparam int NS = 3;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] raw_in;
    logic [W-1:0] clr_flag;
    logic [W-1:0] db_level;
    logic [W-1:0] rise_tick;
    logic [W-1:0] fall_tick;
    logic [W-1:0] edge_flag;

    int n_checks = 0;
    int n_errors = 0;

    gpi_debounce #(
        .W           (W),
        .SYNC_STAGES (2),
        .TICK_W      (2),
        .N_STABLE    (NS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .raw_in    (raw_in),
        .db_level  (db_level),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick),
        .clr_flag  (clr_flag),
        .edge_flag (edge_flag)
    );

    always #5 clk = ~clk;

    // Reference: raw input seen two edges late; a new level is accepted once it
    // has been held across NS tick edges, not counting the edge it first appeared.
    logic [W-1:0] m_sync0, m_sync1, m_db, m_rise, m_fall, m_flag;
    int           m_phase;
    bit           m_diff  [W];
    int           m_ticks [W];
    int           rise_cnt[W];
    int           fall_cnt[W];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_sync0 = '0; m_sync1 = '0; m_db = '0; m_rise = '0; m_fall = '0; m_flag = '0;
        m_phase = 0;
        for (int i = 0; i < W; i++) begin
            m_diff[i] = 1'b0; m_ticks[i] = 0;
        end
    endtask

    task automatic model_edge();
        logic [W-1:0] s;
        bit           tick;
        if (!reset) begin
            model_clear();
            return;
        end
        tick    = (m_phase == 3);
        m_phase = (m_phase + 1) % 4;
        s       = m_sync1;
        m_sync1 = m_sync0;
        m_sync0 = raw_in;
`ifdef GPI_EDGE_LATCH_EN
        m_flag  = (m_flag & ~clr_flag) | m_rise | m_fall;
`endif
        m_rise = '0;
        m_fall = '0;
        for (int i = 0; i < W; i++) begin
            if (s[i] != m_db[i]) begin
                if (!m_diff[i]) begin
                    m_diff[i]  = 1'b1;
                    m_ticks[i] = 0;
                end else if (tick) begin
                    m_ticks[i]++;
                    if (m_ticks[i] == NS) begin
                        m_db[i]   = s[i];
                        m_rise[i] = s[i];
                        m_fall[i] = ~s[i];
                        m_diff[i] = 1'b0;
                    end
                end
            end else begin
                m_diff[i] = 1'b0;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_val("db_level",  32'(db_level),  32'(m_db));
        check_val("rise_tick", 32'(rise_tick), 32'(m_rise));
        check_val("fall_tick", 32'(fall_tick), 32'(m_fall));
        check_val("edge_flag", 32'(edge_flag), 32'(m_flag));
        for (int i = 0; i < W; i++) begin
            rise_cnt[i] += int'(rise_tick[i]);
            fall_cnt[i] += int'(fall_tick[i]);
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        int lat;
        int snap_r;
        int snap_f;
        int r_all[W];
        int n;

        for (int i = 0; i < W; i++) begin
            rise_cnt[i] = 0; fall_cnt[i] = 0;
        end
        model_clear();
        raw_in   = 4'hF;
        clr_flag = '0;
        reset    = 1'b0;
        run(3);
        check_val("rst_db", 32'(db_level), 32'h0);
        check_val("rst_rise", 32'(rise_tick), 32'h0);

        // Power-up with all inputs high
        reset = 1'b1;
        for (int i = 0; i < W; i++) r_all[i] = rise_cnt[i];
        n = 0;
        while (db_level != 4'hF && n < 20) begin step(); n++; end
        check_val("s1_db_all", 32'(db_level), 32'hF);
        check_val("s1_rise_now", 32'(rise_tick), 32'hF);
        step();
        check_val("s1_rise_1cyc", 32'(rise_tick), 32'h0);
        for (int i = 0; i < W; i++)
            check_val("s1_rise_cnt", 32'(rise_cnt[i] - r_all[i]), 32'd1);

        raw_in = 4'h0;
        run(20);
        check_val("s1_db_low", 32'(db_level), 32'h0);

        // Clean step on bit 0 with latency window
        raw_in[0] = 1'b1;
        lat = 0;
        while (!db_level[0] && lat < 20) begin step(); lat++; end
        check_val("s2_lat_window", 32'(lat >= 12 && lat <= 15), 32'd1);
        check_val("s2_rise_coinc", 32'(rise_tick[0]), 32'd1);
        check_val("s2_other_bits", 32'(db_level[3:1]), 32'h0);
        step();
        check_val("s2_rise_1cyc", 32'(rise_tick[0]), 32'd0);

        // Bit 1 chatter faster than a tick period
        snap_r = rise_cnt[1];
        snap_f = fall_cnt[1];
        for (int c = 0; c < 40; c++) begin
            if (c % 3 == 0) raw_in[1] = ~raw_in[1];
            step();
        end
        raw_in[1] = 1'b0;
        run(20);
        check_val("s3_db1", 32'(db_level[1]), 32'd0);
        check_val("s3_no_pulse", 32'((rise_cnt[1] - snap_r) + (fall_cnt[1] - snap_f)), 32'd0);

        // One-cycle glitch on bit 2, synchronized value drops on a tick edge
        snap_r = rise_cnt[2];
        n = 0;
        while (m_phase != 0 && n < 8) begin step(); n++; end
        raw_in[2] = 1'b1;
        step();
        raw_in[2] = 1'b0;
        run(20);
        check_val("s4_db2", 32'(db_level[2]), 32'd0);
        check_val("s4_no_rise", 32'(rise_cnt[2] - snap_r), 32'd0);

        // Asynchronous reset while bit 0 is mid-qualification
        raw_in[0] = 1'b0;
        run(20);
        raw_in[0] = 1'b1;
        run(6);
        reset = 1'b0;
        #1;
        check_val("s5_async_db", 32'(db_level), 32'h0);
        check_val("s5_async_pulses", 32'(rise_tick | fall_tick), 32'h0);
        check_val("s5_async_flag", 32'(edge_flag), 32'h0);
        raw_in = 4'h0;
        run(2);
        reset  = 1'b1;
        snap_r = rise_cnt[0];
        run(30);
        check_val("s5_no_rise", 32'(rise_cnt[0] - snap_r), 32'd0);

`ifdef GPI_EDGE_LATCH_EN
        raw_in[3] = 1'b1;
        run(20);
        clr_flag[3] = 1'b1; step(); clr_flag[3] = 1'b0; step();
        check_val("s6_clr_after_rise", 32'(edge_flag[3]), 32'd0);
        raw_in[3] = 1'b0;
        run(20);
        check_val("s6_fall_sets", 32'(edge_flag[3]), 32'd1);
        clr_flag[3] = 1'b1; step(); clr_flag[3] = 1'b0; step();
        check_val("s6_clr_alone", 32'(edge_flag[3]), 32'd0);
        raw_in[3] = 1'b1;
        n = 0;
        while (!rise_tick[3] && n < 20) begin step(); n++; end
        check_val("s6_rise_seen", 32'(rise_tick[3]), 32'd1);
        clr_flag[3] = 1'b1; step(); clr_flag[3] = 1'b0;
        check_val("s6_set_wins", 32'(edge_flag[3]), 32'd1);
        step();
        check_val("s6_set_holds", 32'(edge_flag[3]), 32'd1);
`else
        check_val("s6_flag_tied", 32'(edge_flag), 32'h0);
`endif

        // Random per-bit toggling, roughly one flip per 12 cycles per bit
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < W; i++)
                if ($urandom_range(0, 11) == 0) raw_in[i] = ~raw_in[i];
            clr_flag = ($urandom_range(0, 3) == 0) ? W'($urandom) : '0;
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
